// File: rtl/mux8x1_rr_arbiter_pkg.sv
// Shared constants and types for the 8-to-1 round-robin collector.
// The same 3-bit index type is used for the pointer, the grant and the output tag.
package mux8x1_rr_arbiter_pkg;

   localparam int DATA_W  = 32;
   localparam int SRC_CNT = 8;
   localparam int SEL_W   = 3;

   typedef logic [SEL_W-1:0] src_idx_t;

   function automatic logic [SRC_CNT-1:0] idx_onehot(input src_idx_t idx);
      return SRC_CNT'(1) << idx;
   endfunction

endpackage

// File: rtl/mux8x1_rr_arbiter_rr_pick8.sv
// Combinational round-robin picker: the first valid source at or after ptr, wrapping mod 8.
// The request vector is rotated so that ptr sits at bit 0, then priority-encoded and un-rotated.
module rr_pick8
   import mux8x1_rr_arbiter_pkg::*;
(
   input  logic [SRC_CNT-1:0] v,
   input  src_idx_t           ptr,
   output src_idx_t           g,
   output logic               any_v
);

   logic [SRC_CNT-1:0] rot;
   src_idx_t           off;

   always_comb begin
      rot = '0;
      off = '0;
      for (int i = 0; i < SRC_CNT; i++) begin
         rot[i] = v[src_idx_t'(ptr + SEL_W'(i))];
      end
      // Scanning downward leaves the lowest set offset as the winner.
      for (int i = SRC_CNT - 1; i >= 0; i--) begin
         if (rot[i]) off = SEL_W'(i);
      end
   end

   assign g     = src_idx_t'(ptr + off);
   assign any_v = |v;

endmodule

// File: rtl/mux8x1_rr_arbiter.sv
// Eight valid/ready sources gathered onto one registered output stage,
// with the winning source index tagged alongside the word.
module mux8x1_rr_arbiter
   import mux8x1_rr_arbiter_pkg::*;
#(
   parameter int N = DATA_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       I0,
   input  logic [N-1:0]       I1,
   input  logic [N-1:0]       I2,
   input  logic [N-1:0]       I3,
   input  logic [N-1:0]       I4,
   input  logic [N-1:0]       I5,
   input  logic [N-1:0]       I6,
   input  logic [N-1:0]       I7,
   input  logic [SRC_CNT-1:0] V,
   output logic [SRC_CNT-1:0] R,
   output logic [N-1:0]       Y,
   output src_idx_t           S,
   output logic               YV,
   input  logic               YR
);

   // Handshake: a word moves whenever valid and ready are both 1 on a rising edge.
   // Sources hold V[k]/Ik until R[k] takes them; V must never depend on R.
   // Downstream sees Y/S/YV registered and drains with YR.

   src_idx_t   ptr;
   src_idx_t   g;
   logic       any_v;
   logic       load_en;
   logic       yv_q;
   logic [N-1:0] src [SRC_CNT];

   assign src[0] = I0;
   assign src[1] = I1;
   assign src[2] = I2;
   assign src[3] = I3;
   assign src[4] = I4;
   assign src[5] = I5;
   assign src[6] = I6;
   assign src[7] = I7;

   rr_pick8 u_pick (
      .v     (V),
      .ptr   (ptr),
      .g     (g),
      .any_v (any_v)
   );

   // The output slot can take a word when empty or when it is being drained this cycle.
   assign load_en = !yv_q || YR;
   assign R       = (rst_n && load_en && any_v) ? idx_onehot(g) : '0;
   assign YV      = yv_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Y    <= '0;
         S    <= '0;
         yv_q <= 1'b0;
         ptr  <= '0;
      end else if (load_en) begin
         if (any_v) begin
            Y    <= src[g];
            S    <= g;
            yv_q <= 1'b1;
            ptr  <= src_idx_t'(g + 3'd1);
         end else begin
            yv_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux8x1_rr_arbiter.sv
// Directed bench for mux8x1_rr_arbiter: reset, single source, round-robin,
// backpressure, wrap-around and asynchronous mid-stream reset.
module tb_mux8x1_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [31:0] i_d [8];
   logic [7:0]  v;
   logic [7:0]  r;
   logic [31:0] y;
   logic [2:0]  s;
   logic        yv;
   logic        yr;

   int n_cmp;
   int n_bad;

   mux8x1_rr_arbiter #(.N(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .I0    (i_d[0]),
      .I1    (i_d[1]),
      .I2    (i_d[2]),
      .I3    (i_d[3]),
      .I4    (i_d[4]),
      .I5    (i_d[5]),
      .I6    (i_d[6]),
      .I7    (i_d[7]),
      .V     (v),
      .R     (r),
      .Y     (y),
      .S     (s),
      .YV    (yv),
      .YR    (yr)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks: every drive happens 1ns after a rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [31:0] base);
      for (int k = 0; k < 8; k++) i_d[k] = base + 32'(k);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      v     = 8'hFF;
      yr    = 1'b1;
      set_data(32'd12321);
      #1;
      n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL reset_r got=%h exp=00", r); end
      n_cmp++; if (yv !== 1'b0) begin n_bad++; $display("FAIL reset_yv got=%b exp=0", yv); end
      n_cmp++; if (y !== 32'd0) begin n_bad++; $display("FAIL reset_y got=%0d exp=0", y); end
      n_cmp++; if (s !== 3'd0) begin n_bad++; $display("FAIL reset_s got=%0d exp=0", s); end
      tick();
      tick();
      n_cmp++; if (yv !== 1'b0 || r !== 8'h00) begin n_bad++; $display("FAIL reset_held yv=%b r=%h exp yv=0 r=00", yv, r); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (r !== 8'h01) begin n_bad++; $display("FAIL reset_first_r got=%h exp=01", r); end
      tick();
      n_cmp++; if (s !== 3'd0 || y !== 32'd12321 || yv !== 1'b1) begin n_bad++; $display("FAIL reset_first_out s=%0d y=%0d yv=%b exp s=0 y=12321 yv=1", s, y, yv); end
   endtask

   task automatic test_single();
      // ptr is 1 here, YV=1, YR=1: same-edge drain and load
      set_data(32'd500);
      i_d[2] = 32'd12321;
      v      = 8'b0000_0100;
      #1;
      n_cmp++; if (r !== 8'b0000_0100) begin n_bad++; $display("FAIL single_r got=%b exp=00000100", r); end
      tick();
      n_cmp++; if (y !== 32'd12321 || s !== 3'd2 || yv !== 1'b1) begin n_bad++; $display("FAIL single_out y=%0d s=%0d yv=%b exp y=12321 s=2 yv=1", y, s, yv); end
      v = 8'h00;
      #1;
      n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL single_idle_r got=%h exp=00", r); end
      tick();
      n_cmp++; if (yv !== 1'b0 || y !== 32'd12321 || s !== 3'd2) begin n_bad++; $display("FAIL single_drain yv=%b y=%0d s=%0d exp yv=0 y=12321 s=2", yv, y, s); end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_s;
      pulse_reset();
      set_data(32'd12321);
      v     = 8'hFF;
      yr    = 1'b1;
      exp_s = 3'd0;
      for (int c = 0; c < 10; c++) begin
         #1;
         n_cmp++; if (r !== (8'h01 << exp_s)) begin n_bad++; $display("FAIL rr_r cyc=%0d got=%b exp_idx=%0d", c, r, exp_s); end
         tick();
         n_cmp++; if (s !== exp_s || y !== 32'd12321 + 32'(exp_s) || yv !== 1'b1) begin n_bad++; $display("FAIL rr_out cyc=%0d s=%0d y=%0d yv=%b exp s=%0d", c, s, y, yv, exp_s); end
         exp_s = exp_s + 3'd1;
      end
   endtask

   task automatic test_backpressure();
      // last grant was 1, so ptr=2 and Y=12322 is pending
      yr = 1'b0;
      v  = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL bp_r cyc=%0d got=%h exp=00", c, r); end
         tick();
         n_cmp++; if (s !== 3'd1 || y !== 32'd12322 || yv !== 1'b1) begin n_bad++; $display("FAIL bp_hold cyc=%0d s=%0d y=%0d yv=%b exp s=1 y=12322 yv=1", c, s, y, yv); end
      end
      yr = 1'b1;
      #1;
      n_cmp++; if (r !== 8'b0000_0100) begin n_bad++; $display("FAIL bp_release_r got=%b exp=00000100", r); end
      tick();
      n_cmp++; if (s !== 3'd2 || y !== 32'd12323 || yv !== 1'b1) begin n_bad++; $display("FAIL bp_release_out s=%0d y=%0d yv=%b exp s=2 y=12323 yv=1", s, y, yv); end
   endtask

   task automatic test_wrap();
      logic [2:0] exp_seq [3];
      exp_seq[0] = 3'd0;
      exp_seq[1] = 3'd7;
      exp_seq[2] = 3'd0;
      // advance through 3..7 with all sources valid
      for (int k = 3; k < 8; k++) tick();
      n_cmp++; if (s !== 3'd7 || y !== 32'd12328) begin n_bad++; $display("FAIL wrap_at7 s=%0d y=%0d exp s=7 y=12328", s, y); end
      v = 8'b1000_0001;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (r !== (8'h01 << exp_seq[c])) begin n_bad++; $display("FAIL wrap_r step=%0d got=%b exp_idx=%0d", c, r, exp_seq[c]); end
         tick();
         n_cmp++; if (s !== exp_seq[c] || y !== 32'd12321 + 32'(exp_seq[c])) begin n_bad++; $display("FAIL wrap_out step=%0d s=%0d y=%0d exp s=%0d", c, s, y, exp_seq[c]); end
      end
   endtask

   task automatic test_reset_mid();
      // YV=1 with S=0 pending; drop reset between edges
      v = 8'hFF;
      tick();
      n_cmp++; if (yv !== 1'b1 || s !== 3'd1) begin n_bad++; $display("FAIL mid_pre yv=%b s=%0d exp yv=1 s=1", yv, s); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (yv !== 1'b0 || y !== 32'd0 || s !== 3'd0 || r !== 8'h00) begin n_bad++; $display("FAIL mid_async yv=%b y=%0d s=%0d r=%h exp all 0", yv, y, s, r); end
      tick();
      v     = 8'b0010_0000;
      rst_n = 1'b1;
      #1;
      n_cmp++; if (r !== 8'b0010_0000) begin n_bad++; $display("FAIL mid_first_r got=%b exp=00100000", r); end
      tick();
      n_cmp++; if (s !== 3'd5 || y !== 32'd12326 || yv !== 1'b1) begin n_bad++; $display("FAIL mid_first_out s=%0d y=%0d yv=%b exp s=5 y=12326 yv=1", s, y, yv); end
      // ptr should now be 6
      v = 8'hFF;
      #1;
      n_cmp++; if (r !== 8'b0100_0000) begin n_bad++; $display("FAIL mid_ptr_r got=%b exp=01000000", r); end
      tick();
      n_cmp++; if (s !== 3'd6 || y !== 32'd12327) begin n_bad++; $display("FAIL mid_next_out s=%0d y=%0d exp s=6 y=12327", s, y); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      v     = 8'h00;
      yr    = 1'b0;
      rst_n = 1'b0;
      set_data(32'd0);
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout sim_time=%0t limit=100000", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mux8x1_rr_arbiter.md
Name: mux8x1_rr_arbiter

Overview:
Gathers eight N-bit source streams onto one shared N-bit bus. It is the collecting counterpart of the Demux1x8 fan-out path.
- Each source offers a word with a valid/ready handshake.
- A round-robin pointer picks one source per cycle.
- The chosen word is captured in a registered output stage, tagged with its 3-bit source index, and presented downstream with its own valid/ready pair.

Parameters:
N, 32, data width of every source word and of the output word.

Ports:
clk  input  1  single clock; every register updates on its rising edge.
rst_n  input  1  asynchronous reset, active-low.
I0..I7  input  N each  source data words 0..7.
V  input  8  source valid; V[k] qualifies Ik.
R  output  8  source ready; a transfer from source k occurs when V[k] and R[k] are both 1 on a rising edge.
Y  output  N  registered output word.
S  output  3  registered index of the source that produced Y.
YV  output  1  output valid.
YR  input  1  downstream ready; the output word is consumed when YV and YR are both 1.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (while rst_n=0 and after release): Y=0, S=0, YV=0, internal pointer ptr=0, and R=8'b0 (R is forced to 0 while rst_n=0).
- load_en = !YV | YR. The output register can accept a word when it is empty or is being drained this cycle.
- Grant selection (combinational):
  - g is the first index in the cyclic order ptr, ptr+1, ..., ptr+7 (mod 8) with V[g]=1.
  - any_v = |V.
- R = onehot(g) when load_en & any_v, otherwise 8'b0. At most one R bit is ever 1.
- R depends combinationally on V, on YR and on ptr. Sources must not make V depend on R.
- Transfer edge (load_en & any_v): Y <= Ig, S <= g, YV <= 1, ptr <= g+1 mod 8 (7 wraps to 0).
- load_en & !any_v: YV <= 0. Y and S hold their last values; ptr holds.
- !load_en (YV=1, YR=0): Y, S, YV and ptr all hold, and R=0. This is backpressure.
- Latency: a word accepted on edge t is visible on Y/S with YV=1 after edge t. That is one cycle from the handshake.
- Throughput: one word per cycle while YR=1 and any_v=1.
- Fairness:
  - A source that holds V=1 is granted within 8 consecutive load_en cycles.
  - With V=8'hFF continuously and YR=1, S cycles 0,1,...,7,0,...
- Source obligations: once V[k]=1, source k holds V[k] and Ik stable until its transfer.
- Simultaneous drain and load (YV=1, YR=1, any_v=1) on the same edge: the old word is consumed, the new word is loaded, and YV stays 1.
- Reset mid-stream:
  - YV drops to 0 immediately (asynchronously) and any pending output word is discarded.
  - ptr returns to 0, so the first grant after release is the lowest-indexed valid source.
- Widths: the pointer, g and S are all 3 bits, and all index arithmetic is modulo 8.

Decomposition:
- Shared package holds:
  - the default data width constant (32);
  - SRC_CNT=8;
  - SEL_W=3;
  - a 3-bit source-index typedef used for S, ptr and g.
- One combinational sub-module is natural: rr_pick8. It takes V and ptr and returns g and any_v, using a rotate, priority-encode, un-rotate scheme.
- The top level holds ptr, the output register and the handshake logic.

Test Plan:
1. Reset: assert rst_n=0 with V=8'hFF and YR=1 -> R=0, YV=0, Y=0, S=0; after release the first grant has R=8'b0000_0001.
2. Single source: V=8'b0000_0100, I2=32'd12321, YR=1 -> R=8'b0000_0100 that cycle; after the next edge Y=32'd12321, S=2, YV=1; with V then 0, YV=0 one edge later.
3. Full round-robin: V=8'hFF, Ik=32'd12321+k, YR=1 for 10 cycles -> S=0,1,2,...,7,0,1 and Y=12321+S on every cycle; exactly one R bit is high each cycle.
4. Backpressure: YV=1 with YR=0 for 3 cycles -> R=0, and Y/S/ptr are unchanged. With YR=1 again, the same-edge drain and load keeps YV=1 and the next source is granted.
5. Wrap-around: after a grant of source 7, apply V=8'b1000_0001 -> source 0 is granted next, then source 7, then source 0.
6. Reset mid-stream: drop rst_n asynchronously between edges with YV=1 -> YV, Y and S go to 0 without a clock. After release with V=8'b0010_0000, the grant goes to source 5 and ptr becomes 6.
